// File: rtl/id_imm_ctrl.sv
// Decode-side immediate controller: classifies the instruction, extends its immediate, and buffers it in a 2-entry skid queue.
// Latency 1 cycle; in_ready is derived only from the registered occupancy. Optional out_target adder under IMMCTRL_TARGET_EN.

module id_imm_ext (
    input  logic [2:0]  ext_op,
    input  logic [25:0] din,
    output logic [31:0] dout
);
    localparam logic [2:0] EXT_20    = 3'd1;
    localparam logic [2:0] EXT_12    = 3'd2;
    localparam logic [2:0] EXT_12Z   = 3'd3;
    localparam logic [2:0] EXT_5     = 3'd4;
    localparam logic [2:0] EXT_2RI16 = 3'd5;
    localparam logic [2:0] EXT_I26   = 3'd6;

    always_comb begin
        dout = '0;
        case (ext_op)
            EXT_20:    dout = {din[24:5], 12'h000};
            EXT_12:    dout = {{20{din[21]}}, din[21:10]};
            EXT_12Z:   dout = {20'h00000, din[21:10]};
            EXT_5:     dout = {27'h0000000, din[14:10]};
            EXT_2RI16: dout = {{14{din[25]}}, din[25:10], 2'b00};
            // offs26 is split: high bits live in inst[9:0], low bits in inst[25:10]
            EXT_I26:   dout = {{4{din[9]}}, din[9:0], din[25:10], 2'b00};
            default:   dout = '0;
        endcase
    end
endmodule

module id_imm_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [2:0]  out_ext_op,
    output logic [31:0] out_imm,
    output logic        out_has_imm
`ifdef IMMCTRL_TARGET_EN
    ,
    output logic [31:0] out_target
`endif
);
    localparam logic [2:0] EXT_NONE  = 3'd0;
    localparam logic [2:0] EXT_20    = 3'd1;
    localparam logic [2:0] EXT_12    = 3'd2;
    localparam logic [2:0] EXT_12Z   = 3'd3;
    localparam logic [2:0] EXT_5     = 3'd4;
    localparam logic [2:0] EXT_2RI16 = 3'd5;
    localparam logic [2:0] EXT_I26   = 3'd6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  ext_op;
        logic [31:0] imm;
        logic        has_imm;
    } entry_t;

    logic [2:0]  dec_op;
    logic        dec_has;
    logic [31:0] dec_imm;

    entry_t      mem [DEPTH];
    logic        head_ptr;
    logic        tail_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    entry_t      head;

    always_comb begin
        dec_op  = EXT_NONE;
        dec_has = 1'b1;
        if (in_inst[31:25] == 7'b0001010 || in_inst[31:25] == 7'b0001110) begin
            dec_op = EXT_20;
        end else if (in_inst[31:22] inside {10'b0000001000, 10'b0000001001, 10'b0000001010} ||
                     in_inst[31:25] == 7'b0010100) begin
            dec_op = EXT_12;
        end else if (in_inst[31:22] inside {10'b0000001101, 10'b0000001110, 10'b0000001111}) begin
            dec_op = EXT_12Z;
        end else if (in_inst[31:15] inside {17'b00000000010000001, 17'b00000000010001001,
                                            17'b00000000010010001}) begin
            dec_op = EXT_5;
        end else if (in_inst[31:26] == 6'b010011 ||
                     (in_inst[31:26] >= 6'b010110 && in_inst[31:26] <= 6'b011011)) begin
            dec_op = EXT_2RI16;
        end else if (in_inst[31:26] == 6'b010100 || in_inst[31:26] == 6'b010101) begin
            dec_op = EXT_I26;
        end else begin
            dec_has = 1'b0;
        end
    end

    id_imm_ext u_ext (
        .ext_op (dec_op),
        .din    (in_inst[25:0]),
        .dout   (dec_imm)
    );

    // Ready comes from registered occupancy only, so out_ready never reaches in_ready
    assign in_ready  = (count != DEPTH[1:0]);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                mem[tail_ptr] <= '{pc: in_pc, inst: in_inst, ext_op: dec_op,
                                   imm: dec_imm, has_imm: dec_has};
                tail_ptr      <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head        = mem[head_ptr];
    assign out_pc      = head.pc;
    assign out_inst    = head.inst;
    assign out_ext_op  = head.ext_op;
    assign out_imm     = head.imm;
    assign out_has_imm = head.has_imm;

`ifdef IMMCTRL_TARGET_EN
    assign out_target = head.pc + head.imm;
`endif

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Randomized scoreboard bench for id_imm_ctrl with an arithmetic reference model of the immediate formats.
module tb_id_imm_ctrl;
    localparam logic [2:0] OP_NONE = 3'd0, OP_20 = 3'd1, OP_12 = 3'd2, OP_12Z = 3'd3,
                           OP_5 = 3'd4, OP_2RI16 = 3'd5, OP_I26 = 3'd6;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready, out_has_imm;
    logic [31:0] in_pc, in_inst, out_pc, out_inst, out_imm, out_target;
    logic [2:0]  out_ext_op;

    always #5 clk = ~clk;

    id_imm_ctrl #(.DEPTH(2)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_ext_op(out_ext_op), .out_imm(out_imm), .out_has_imm(out_has_imm)
`ifdef IMMCTRL_TARGET_EN
        , .out_target(out_target)
`endif
    );
`ifndef IMMCTRL_TARGET_EN
    assign out_target = '0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  op;
        logic [31:0] imm;
        logic        has;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   npops = 0;
    bit   started = 0;
    logic acc_s, fl_s, rst_s;
    logic [31:0] pc_s, inst_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        int   v;
        e.pc = pc; e.inst = inst; e.has = 1'b1; e.op = OP_NONE; e.imm = '0;
        if (inst[31:25] == 7'h0A || inst[31:25] == 7'h0E) begin
            e.op = OP_20; e.imm = 32'(inst[24:5]) * 32'd4096;
        end else if (inst[31:22] == 10'h008 || inst[31:22] == 10'h009 ||
                     inst[31:22] == 10'h00A || inst[31:25] == 7'h14) begin
            v = int'(inst[21:10]);
            if (v >= 2048) v = v - 4096;
            e.op = OP_12; e.imm = 32'(v);
        end else if (inst[31:22] >= 10'h00D && inst[31:22] <= 10'h00F) begin
            e.op = OP_12Z; e.imm = 32'(inst[21:10]);
        end else if (inst[31:15] == 17'h00081 || inst[31:15] == 17'h00089 ||
                     inst[31:15] == 17'h00091) begin
            e.op = OP_5; e.imm = 32'(inst[14:10]);
        end else if (inst[31:26] == 6'h13 || (inst[31:26] >= 6'h16 && inst[31:26] <= 6'h1B)) begin
            v = int'(inst[25:10]);
            if (v >= 32768) v = v - 65536;
            e.op = OP_2RI16; e.imm = 32'(v * 4);
        end else if (inst[31:26] == 6'h14 || inst[31:26] == 6'h15) begin
            v = int'(inst[9:0]) * 65536 + int'(inst[25:10]);
            if (v >= (1 << 25)) v = v - (1 << 26);
            e.op = OP_I26; e.imm = 32'(v * 4);
        end else begin
            e.has = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        logic [6:0]  o7;
        logic [9:0]  o10;
        logic [5:0]  o6;
        logic [16:0] o17;
        r = $urandom;
        case ($urandom_range(0, 8))
            0: begin o7 = ($urandom_range(0, 1) != 0) ? 7'h0A : 7'h0E; return {o7, r[24:0]}; end
            1: begin o10 = 10'h008 + 10'($urandom_range(0, 2)); return {o10, r[21:0]}; end
            2: begin o7 = 7'h14; return {o7, r[24:0]}; end
            3: begin o10 = 10'h00D + 10'($urandom_range(0, 2)); return {o10, r[21:0]}; end
            4: begin
                o17 = ($urandom_range(0, 2) == 0) ? 17'h00081 :
                      (($urandom_range(0, 1) == 0) ? 17'h00089 : 17'h00091);
                return {o17, r[14:0]};
            end
            5: begin o6 = ($urandom_range(0, 6) == 0) ? 6'h13 : 6'(6'h16 + $urandom_range(0, 5));
                     return {o6, r[25:0]}; end
            6: begin o6 = ($urandom_range(0, 1) != 0) ? 6'h14 : 6'h15; return {o6, r[25:0]}; end
            default: return r;
        endcase
    endfunction

    // Capture the handshake mid-cycle, apply it to the expected queue at the edge
    always @(negedge clk) begin
        acc_s  = in_valid && in_ready && !flush;
        fl_s   = flush;
        rst_s  = !resetn;
        pc_s   = in_pc;
        inst_s = in_inst;
        @(posedge clk);
        if (rst_s || fl_s) sb.delete();
        else if (acc_s) sb.push_back(model(pc_s, inst_s));
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            chk("in_ready", 32'(in_ready), 32'(sb.size() != 2));
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (resetn && out_valid && out_ready && !flush && sb.size() != 0) begin
                e = sb.pop_front();
                npops++;
                chk("out_pc", out_pc, e.pc);
                chk("out_inst", out_inst, e.inst);
                chk("out_ext_op", 32'(out_ext_op), 32'(e.op));
                chk("out_imm", out_imm, e.imm);
                chk("out_has_imm", 32'(out_has_imm), 32'(e.has));
`ifdef IMMCTRL_TARGET_EN
                chk("out_target", out_target, e.pc + e.imm);
`endif
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl);
        in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && sb.size() != 0; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic directed(input string name, input logic [31:0] pc, input logic [31:0] inst,
                            input logic [2:0] op, input logic [31:0] imm, input logic has);
        step(1'b1, pc, inst, 1'b0, 1'b0);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_op"}, 32'(out_ext_op), 32'(op));
        chk({name, "_imm"}, out_imm, imm);
        chk({name, "_has"}, 32'(out_has_imm), 32'(has));
`ifdef IMMCTRL_TARGET_EN
        chk({name, "_target"}, out_target, pc + imm);
`endif
        drain();
    endtask

    initial begin
        int p0;
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_has", 32'(out_has_imm), 32'd0);
        chk("rst_out_op", 32'(out_ext_op), 32'd0);
        chk("rst_out_target", out_target, 32'd0);
        resetn = 1'b1;
        started = 1'b1;

        directed("addi1", 32'h1C000000, 32'h02800421, OP_12, 32'h00000001, 1'b1);
        directed("orifff", 32'h1C000004, 32'h03BFFC00, OP_12Z, 32'h00000FFF, 1'b1);
        directed("addifff", 32'h1C000008, 32'h02BFFC00, OP_12, 32'hFFFFFFFF, 1'b1);
        directed("b_m1", 32'h1C000010, 32'h53FFFFFF, OP_I26, 32'hFFFFFFFC, 1'b1);
        directed("addw", 32'h1C000014, 32'h00100C41, OP_NONE, 32'h00000000, 1'b0);

        // Backpressure: three pushes with out_ready low, only two land
        step(1'b1, 32'h100, 32'h02800421, 1'b0, 1'b0);
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        step(1'b1, 32'h104, 32'h03BFFC00, 1'b0, 1'b0);
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        step(1'b1, 32'h108, 32'h53FFFFFF, 1'b0, 1'b0);
        chk("bp_rdy3", 32'(in_ready), 32'd0);
        chk("bp_head", out_pc, 32'h100);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("bp_rdy_after_pop", 32'(in_ready), 32'd1);
        chk("bp_next_head", out_pc, 32'h104);
        drain();

        // Flush while full with a same-cycle input
        step(1'b1, 32'h200, 32'h02800421, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'h02800421, 1'b0, 1'b0);
        step(1'b1, 32'h208, 32'h02800421, 1'b0, 1'b1);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset mid-transfer discards entries and zeroes data
        step(1'b1, 32'h300, 32'h02800421, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'h02800421, 1'b0, 1'b0);
        resetn = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        resetn = 1'b1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_out_pc", out_pc, 32'd0);
        chk("mr_out_imm", out_imm, 32'd0);

        // Full-rate stream
        p0 = npops;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h400 + 32'(i * 4), gen_inst(), 1'b1, 1'b0);
            chk("tp_in_ready", 32'(in_ready), 32'd1);
            chk("tp_out_valid", 32'(out_valid), 32'd1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("tp_pops", 32'(npops - p0), 32'd20);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                resetn = 1'b0;
                step(1'($urandom_range(0, 1)), $urandom, gen_inst(), 1'b1, 1'b0);
                resetn = 1'b1;
            end else begin
                step($urandom_range(0, 3) != 0, $urandom, gen_inst(),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
